// File: rtl/cg_ctrl_pkg.sv
// cg_ctrl_pkg: shared types and constants for the clock-gating controller.
//   cg_state_e  - per-channel FSM state (OFF, WAKE, ON, IDLE)
//   WAKE_CNT_W  - width of the wake-up delay counter
//   STAT_W      - width of each per-channel wake-event counter
package cg_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } cg_state_e;

  localparam int WAKE_CNT_W = 3;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/cg_ctrl_if.sv
// cg_ctrl_if: request/status bundle between the DMA channels and cg_ctrl.
//   ch_req   - per-channel clock request (level)
//   ch_busy  - per-channel activity, keeps the clock alive like ch_req
//   idle_thr - shared idle timeout, sampled on IDLE entry
//   ch_ack   - clock running and stable
//   ch_gated - channel is in OFF
// modport master: the channel side; modport slave: the controller.
interface cg_ctrl_if #(
  parameter int N_CH   = 4,
  parameter int IDLE_W = 8
);
  logic [N_CH-1:0]   ch_req;
  logic [N_CH-1:0]   ch_busy;
  logic [IDLE_W-1:0] idle_thr;
  logic [N_CH-1:0]   ch_ack;
  logic [N_CH-1:0]   ch_gated;

  modport master (output ch_req, ch_busy, idle_thr, input ch_ack, ch_gated);
  modport slave  (input ch_req, ch_busy, idle_thr, output ch_ack, ch_gated);
endinterface

// File: rtl/cg_chan_fsm.sv
// cg_chan_fsm: one channel's gating FSM, wake/idle counters and optional
// wake-event statistics.
//   clk, rst_n - clock, synchronous active-low reset
//   act        - ch_req | ch_busy for this channel
//   idle_thr   - idle timeout, captured on IDLE entry
//   en         - registered gate enable
//   ack        - registered clock-stable flag
//   gated      - registered "in OFF" flag
//   wake_cnt   - saturating OFF->WAKE counter (tied to 0 unless
//                CG_CTRL_STATS_EN is defined)
module cg_chan_fsm
  import cg_ctrl_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              act,
  input  logic [IDLE_W-1:0] idle_thr,
  output logic              en,
  output logic              ack,
  output logic              gated,
  output logic [STAT_W-1:0] wake_cnt
);
  cg_state_e             state;
  logic [WAKE_CNT_W-1:0] wcnt;
  logic [IDLE_W-1:0]     icnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= OFF;
      en    <= 1'b0;
      ack   <= 1'b0;
      gated <= 1'b1;
      wcnt  <= '0;
      icnt  <= '0;
    end else begin
      case (state)
        OFF: if (act) begin
          state <= WAKE;
          en    <= 1'b1;
          gated <= 1'b0;
          wcnt  <= WAKE_CNT_W'(WAKE_CYC - 1);
        end
        // act dropping here is ignored: the wake always completes to ON
        WAKE: if (wcnt == '0) begin
          state <= ON;
          ack   <= 1'b1;
        end else begin
          wcnt <= wcnt - 1'b1;
        end
        ON: if (!act) begin
          if (idle_thr == '0) begin
            state <= OFF;
            en    <= 1'b0;
            ack   <= 1'b0;
            gated <= 1'b1;
          end else begin
            state <= IDLE;
            icnt  <= idle_thr;
          end
        end
        // activity wins over expiry in the same cycle
        IDLE: if (act) begin
          state <= ON;
        end else if (icnt == '0) begin
          state <= OFF;
          en    <= 1'b0;
          ack   <= 1'b0;
          gated <= 1'b1;
        end else begin
          icnt <= icnt - 1'b1;
        end
        default: state <= OFF;
      endcase
    end
  end

`ifdef CG_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      wake_cnt <= '0;
    else if (state == OFF && act && wake_cnt != '1)
      wake_cnt <= wake_cnt + STAT_W'(1);
  end
`else
  assign wake_cnt = '0;
`endif
endmodule

// File: rtl/v_cg.sv
// v_cg: latch-based clock gate cell.
//   clk       - free-running clock
//   clk_en    - registered enable (changes only after rising edges)
//   test_mode - forces the gate transparent
//   clk_out   - gated clock
// The enable is captured while clk is low and held through the high phase,
// so a high pulse is either fully passed or fully suppressed.
module v_cg (
  input  logic clk,
  input  logic clk_en,
  input  logic test_mode,
  output logic clk_out
);
  logic en_l;

  always_latch begin
    if (!clk) en_l <= clk_en | test_mode;
  end

  assign clk_out = clk & en_l;
endmodule

// File: rtl/cg_ctrl.sv
// cg_ctrl: multi-channel automatic clock-gating controller.
//   clk, rst_n - clock, synchronous active-low reset
//   test_mode  - forces all gates transparent (FSMs unaffected)
//   bus        - cg_ctrl_if.slave: ch_req, ch_busy, idle_thr in; ch_ack,
//                ch_gated out
//   clk_out    - per-channel gated clocks
//   wake_cnt   - per-channel wake-event counters
// Optional feature macro: CG_CTRL_STATS_EN (enables wake_cnt counting;
// otherwise wake_cnt reads 0, port list unchanged).
module cg_ctrl
  import cg_ctrl_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         test_mode,
  cg_ctrl_if.slave                     bus,
  output logic [N_CH-1:0]              clk_out,
  output logic [N_CH-1:0][STAT_W-1:0]  wake_cnt
);
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] ack;
  logic [N_CH-1:0] gated;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cg_chan_fsm #(
      .IDLE_W  (IDLE_W),
      .WAKE_CYC(WAKE_CYC)
    ) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .act     (bus.ch_req[i] | bus.ch_busy[i]),
      .idle_thr(bus.idle_thr),
      .en      (en[i]),
      .ack     (ack[i]),
      .gated   (gated[i]),
      .wake_cnt(wake_cnt[i])
    );

    v_cg u_cg (
      .clk      (clk),
      .clk_en   (en[i]),
      .test_mode(test_mode),
      .clk_out  (clk_out[i])
    );
  end

  assign bus.ch_ack   = ack;
  assign bus.ch_gated = gated;
endmodule

// File: tb/tb_cg_ctrl.sv
// tb_cg_ctrl: scoreboard bench for cg_ctrl. A reference model works in
// absolute cycle numbers (open time, ack time, close deadline) and pushes the
// expected outputs per edge; a monitor pops and compares 1 time unit later.
module tb_cg_ctrl;
  localparam int N_CH     = 4;
  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;

  typedef struct {
    logic [N_CH-1:0]       ack;
    logic [N_CH-1:0]       gated;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0][15:0] wc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_mode = 1'b0;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0][15:0] wake_cnt;

  cg_ctrl_if #(.N_CH(N_CH), .IDLE_W(IDLE_W)) bus ();

  cg_ctrl #(.N_CH(N_CH), .IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .test_mode(test_mode),
    .bus      (bus),
    .clk_out  (clk_out),
    .wake_cnt (wake_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;
  bit seeded = 1'b0;
  bit open_m[N_CH];
  int ack_from[N_CH];
  int close_at[N_CH];
  int wakes[N_CH];

  always @(posedge clk) begin
    exp_t e;
    bit   do_push;
    bit   a;
    int   thr;
    do_push = seeded;
    cyc++;
    thr = int'(bus.idle_thr);
    for (int i = 0; i < N_CH; i++) begin
      // high phase now starting carries the enable held since the last edge
      e.clk_out[i] = (seeded && open_m[i]) | test_mode;
      a = bus.ch_req[i] | bus.ch_busy[i];
      if (!rst_n) begin
        open_m[i] = 1'b0; close_at[i] = -1; wakes[i] = 0; ack_from[i] = 0;
      end else if (!open_m[i]) begin
        if (a) begin
          open_m[i] = 1'b1;
          ack_from[i] = cyc + WAKE_CYC;
          close_at[i] = -1;
          if (wakes[i] < 65535) wakes[i]++;
        end
      end else if (cyc > ack_from[i]) begin
        if (close_at[i] < 0) begin
          if (!a) begin
            if (thr == 0) open_m[i] = 1'b0;
            else close_at[i] = cyc + thr + 1;
          end
        end else if (a) begin
          close_at[i] = -1;
        end else if (cyc == close_at[i]) begin
          open_m[i] = 1'b0;
        end
      end
      e.ack[i]   = open_m[i] && (cyc >= ack_from[i]);
      e.gated[i] = !open_m[i];
`ifdef CG_CTRL_STATS_EN
      e.wc[i] = 16'(wakes[i]);
`else
      e.wc[i] = 16'h0;
`endif
    end
    if (!rst_n) seeded = 1'b1;
    if (do_push) sb.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ch_ack",   64'(bus.ch_ack),   64'(e.ack));
      chk("ch_gated", 64'(bus.ch_gated), 64'(e.gated));
      chk("clk_out",  64'(clk_out),      64'(e.clk_out));
      chk("wake_cnt", 64'(wake_cnt),     64'(e.wc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cw(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic [15:0] exp_w;
    bus.ch_req = '0;
    bus.ch_busy = '0;
    bus.idle_thr = 8'd5;
    cw(3);
    rst_n = 1'b1;
    cw(20);                       // silent after reset
    test_mode = 1'b1;
    cw(5);
    test_mode = 1'b0;
    cw(3);

    // wake and idle close on channel 0
    bus.ch_req[0] = 1'b1;
    cw(15);
    bus.ch_req[0] = 1'b0;
    cw(12);
    chk("idle_close_gated0", 64'(bus.ch_gated[0]), 64'd1);
    chk("idle_close_ack0",   64'(bus.ch_ack[0]),   64'd0);

    // re-activation of channel 1 at counter 1, then act on expiry cycle
    bus.ch_req[1] = 1'b1;
    cw(6);
    bus.ch_req[1] = 1'b0;
    cw(5);
    bus.ch_busy[1] = 1'b1;
    cw(1);
    bus.ch_busy[1] = 1'b0;
    cw(6);
    bus.ch_busy[1] = 1'b1;
    cw(1);
    bus.ch_busy[1] = 1'b0;
    cw(12);
    chk("reopen_closed_gated1", 64'(bus.ch_gated[1]), 64'd1);

    // idle_thr=0: ten wake events on channel 2 from a fresh reset
    rst_n = 1'b0;
    cw(1);
    rst_n = 1'b1;
    bus.idle_thr = 8'd0;
    for (int k = 0; k < 10; k++) begin
      bus.ch_req[2] = 1'b1;
      cw(4);
      bus.ch_req[2] = 1'b0;
      cw(4);
    end
`ifdef CG_CTRL_STATS_EN
    exp_w = 16'd10;
`else
    exp_w = 16'd0;
`endif
    chk("wake_cnt2_toggle", 64'(wake_cnt[2]), 64'(exp_w));

    // reset with channel 0 in IDLE and channel 3 in WAKE
    bus.idle_thr = 8'd8;
    bus.ch_req[0] = 1'b1;
    cw(6);
    bus.ch_req[0] = 1'b0;
    cw(2);
    bus.ch_req[3] = 1'b1;
    cw(1);
    rst_n = 1'b0;
    cw(2);
    rst_n = 1'b1;
    bus.ch_req[3] = 1'b0;
    chk("rst_mid_gated", 64'(bus.ch_gated), 64'hF);
    chk("rst_mid_ack",   64'(bus.ch_ack),   64'h0);
    chk("rst_mid_wcnt",  64'(wake_cnt),     64'h0);
    cw(5);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(7) == 0) bus.ch_req[i] = ~bus.ch_req[i];
        bus.ch_busy[i] = ($urandom_range(15) == 0);
      end
      if ($urandom_range(63) == 0) bus.idle_thr = 8'($urandom_range(6));
      test_mode = ($urandom_range(19) == 0);
      rst_n = ($urandom_range(499) != 0);
      cw(1);
    end
    rst_n = 1'b1;
    test_mode = 1'b0;
    bus.ch_req = '0;
    bus.ch_busy = '0;
    cw(30);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cg_ctrl.md
# cg_ctrl

Multi-channel automatic clock-gating controller for the DMA subsystem. Each of N_CH channels requests its gated clock via `ch_req`. The controller opens that channel's clock gate, holds it open while the channel is active, and closes it after a programmable idle timeout. `ch_ack` tells the consumer when its clock is stable; one latch-based gate cell per channel produces `clk_out`.

## Interface
- `N_CH`, 4: number of gated channels (1..16).
- `IDLE_W`, 8: width of the idle-timeout counter and of `idle_thr`.
- `WAKE_CYC`, 2: cycles from gate enable to `ch_ack` assertion (1..7).
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `test_mode` in 1: forces every gate transparent; the FSMs keep running.
- `idle_thr` in IDLE_W: idle cycles before a gate closes; shared by all channels, sampled on IDLE entry.
- `ch_req` in N_CH: per-channel clock request (level).
- `ch_busy` in N_CH: per-channel activity; keeps the clock alive like `ch_req`.
- `ch_ack` out N_CH: clock running and stable.
- `ch_gated` out N_CH: 1 when the channel is in OFF.
- `clk_out` out N_CH: gated clocks.
- `wake_cnt` out N_CH*16: per-channel wake-event counters; see Configuration.

## Operation
- Each channel runs an independent FSM with a registered enable `en[i]`.
- Per channel, `act = ch_req[i] | ch_busy[i]`.
- States:
  - OFF: `en=0`, `ack=0`. If `act`, go to WAKE and load the wake counter with WAKE_CYC-1.
  - WAKE: `en=1`, `ack=0`. Decrement each cycle; at 0 go to ON. `act` dropping during WAKE does not abort; the FSM completes to ON.
  - ON: `en=1`, `ack=1`. If `!act`, go to IDLE and load the idle counter with `idle_thr`. If `idle_thr==0`, go directly to OFF instead.
  - IDLE: `en=1`, `ack=1`.
    - If `act`, return to ON; the counter is discarded.
    - Otherwise decrement; when the counter is 0, go to OFF. `act` has priority over expiry in the same cycle.
- Gate cell function: `clk_out[i] = clk & latch(en[i] | test_mode)`, with the latch transparent while `clk` is low. The gate never produces a glitch or a truncated high pulse.
- `test_mode` affects only the gate cell. `ch_ack` and `ch_gated` still follow the FSM.
- `idle_thr` changes apply only on the next IDLE entry.
- Reset values: all FSMs in OFF, `en=0`, `ch_ack=0`, `ch_gated` all 1s, `wake_cnt=0`. `clk_out` is low from the first low phase after reset is sampled, unless `test_mode=1`.
- Reset mid-operation: any state goes to OFF on the sampling edge. The in-flight high phase completes and no further pulses follow.

## Timing
- OFF→ack latency: `act` sampled at edge T. `en` is high after T, the first `clk_out` pulse is in cycle T+1, and `ch_ack` rises at edge T+WAKE_CYC.
- Idle close: `act` last low-sampled at edge T enters IDLE. `en` falls at edge T+`idle_thr`+1, and the last `clk_out` pulse is in that cycle.
- `ch_ack` and `ch_gated` are registered outputs with no combinational input→output path.
- `clk_out` lags `en` by half a cycle (latch on the low phase).

## Configuration
- Macro: `CG_CTRL_STATS_EN`.
- Defined: `wake_cnt[i]` increments on every OFF→WAKE transition of channel i and saturates at 0xFFFF. It clears only on reset.
- Undefined: the counter logic is removed and `wake_cnt` is tied to 0. The port list is identical in both builds.

## Structure
- Package `cg_ctrl_pkg`:
  - the `cg_state_e` enum (OFF, WAKE, ON, IDLE; 2-bit);
  - the `WAKE_CNT_W=3` and `STAT_W=16` constants.
- Sub-module `cg_chan_fsm`: one channel's FSM, counters and optional stats. It is generated N_CH times.
- Each channel feeds one instance of the existing `v_cg` gate cell, with `clk_en=en[i]` and `test_mode` passed through.

## Test plan
- Reset with `ch_req=0`: `ch_ack=0`, `ch_gated=4'hF`, no `clk_out` edges for 20 cycles; `test_mode=1` → all four `clk_out` toggle.
- Wake: `ch_req[0]` goes 1 at edge 10, WAKE_CYC=2 → `clk_out[0]` first pulse in cycle 11, `ch_ack[0]` rises at edge 12, other channels stay silent.
- Idle close: `idle_thr=5`, drop `ch_req[0]` at edge 30 → exactly 6 more `clk_out[0]` pulses, then `ch_gated[0]=1`, `ch_ack[0]=0`.
- Re-activation: `ch_busy[1]` pulses during IDLE at counter=1 → back to ON, no gate closure, `wake_cnt[1]` unchanged. With the counter reaching 0 and `act` high in the same cycle, the FSM stays open.
- `idle_thr=0`, toggle `ch_req[2]` 1/0 every 4 cycles for 10 periods → 10 wake events. With `CG_CTRL_STATS_EN`, `wake_cnt[2]=10`; without it, 0.
- Reset asserted while channel 3 is in WAKE and channel 0 in IDLE → both OFF at the next edge, no partial `clk_out` pulse, `wake_cnt` cleared.
